// File: rtl/fifo_mem_mc.sv
// fifo_mem_mc: multi-channel dual-clock storage array with byte-lane writes and tagged reads.
// Latency: write lands on the accepting i_wclk edge; read data/valid appear READ_LAT (1 or 2) i_rclk edges after acceptance.
// Backpressure: none issued; requests to full/empty (or nonexistent) channels are dropped and counted (saturating).
//
// Ports:
//   i_wclk, i_rclk       write / read domain clocks
//   i_reset_n            async active-low reset, both domains (deassertion synchronised outside)
//   i_wr_en/_ch/addr     write request, channel, entry; i_wbe lane enables; i_DATA write word
//   i_full               per-channel full flags (wclk domain) gating writes
//   i_rd_en/_ch/addr     read request, channel, entry; i_empty per-channel empty flags (rclk domain)
//   o_DATA, o_rd_ch      registered read word and its channel tag, held between reads
//   o_rvalid             one-cycle strobe marking a new o_DATA
//   o_wr_ovf_cnt         blocked-write count (wclk domain); o_rd_unf_cnt blocked-read count (rclk domain)
module fifo_mem_mc #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int LANES    = 4,
  parameter  int READ_LAT = 1,
  parameter  int CNT_W    = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               i_wclk,
  input  logic               i_rclk,
  input  logic               i_reset_n,
  input  logic               i_wr_en,
  input  logic [CW-1:0]      i_wr_ch,
  input  logic [AW-1:0]      i_wraddr,
  input  logic [LANES-1:0]   i_wbe,
  input  logic [WIDTH-1:0]   i_DATA,
  input  logic [CHANNELS-1:0] i_full,
  input  logic               i_rd_en,
  input  logic [CW-1:0]      i_rd_ch,
  input  logic [AW-1:0]      i_rdaddr,
  input  logic [CHANNELS-1:0] i_empty,
  output logic [WIDTH-1:0]   o_DATA,
  output logic               o_rvalid,
  output logic [CW-1:0]      o_rd_ch,
  output logic [CNT_W-1:0]   o_wr_ovf_cnt,
  output logic [CNT_W-1:0]   o_rd_unf_cnt
);

  localparam int LW      = WIDTH / LANES;
  localparam int ENTRIES = CHANNELS * DEPTH;

  // Storage: channel-major, entry index is {channel, address}.
  logic [WIDTH-1:0] r_mem [ENTRIES];

  logic [CNT_W-1:0] r_wr_ovf_cnt;
  logic [CNT_W-1:0] r_rd_unf_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic [CW-1:0]    r_rd_ch;

  logic [CW-1:0]    w_wr_ch;
  logic [CW-1:0]    w_rd_ch;
  logic             w_wr_hit;
  logic             w_wr_full;
  logic             w_rd_hit;
  logic             w_rd_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW+AW-1:0] w_wr_idx;
  logic [CW+AW-1:0] w_rd_idx;
  logic [WIDTH-1:0] w_rd_word;

  // A single-channel instance has no channel select; force it to 0.
  assign w_wr_ch = (CHANNELS == 1) ? '0 : i_wr_ch;
  assign w_rd_ch = (CHANNELS == 1) ? '0 : i_rd_ch;

  // Channel decode by match loop: a select beyond CHANNELS-1 matches nothing,
  // which both rejects it and avoids indexing the flag vectors out of range.
  always_comb begin
    w_wr_hit   = 1'b0;
    w_wr_full  = 1'b0;
    w_rd_hit   = 1'b0;
    w_rd_empty = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr_ch == CW'(c)) begin
        w_wr_hit  = 1'b1;
        w_wr_full = i_full[c];
      end
      if (w_rd_ch == CW'(c)) begin
        w_rd_hit   = 1'b1;
        w_rd_empty = i_empty[c];
      end
    end
  end

  assign w_wr_acc  = i_wr_en & w_wr_hit & ~w_wr_full;
  assign w_rd_acc  = i_rd_en & w_rd_hit & ~w_rd_empty;
  assign w_wr_idx  = {w_wr_ch, i_wraddr};
  assign w_rd_idx  = {w_rd_ch, i_rdaddr};
  assign w_rd_word = r_mem[w_rd_idx];

  // Write domain: lane-masked update, otherwise count the blocked attempt.
  always_ff @(posedge i_wclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_mem[e] <= '0;
      end
      r_wr_ovf_cnt <= '0;
    end else if (i_wr_en) begin
      if (w_wr_acc) begin
        for (int k = 0; k < LANES; k++) begin
          if (i_wbe[k]) begin
            r_mem[w_wr_idx][k*LW +: LW] <= i_DATA[k*LW +: LW];
          end
        end
      end else if (r_wr_ovf_cnt != {CNT_W{1'b1}}) begin
        r_wr_ovf_cnt <= r_wr_ovf_cnt + 1'b1;
      end
    end
  end

  // Read domain: blocked-read counter.
  always_ff @(posedge i_rclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_unf_cnt <= '0;
    end else if (i_rd_en && !w_rd_acc && (r_rd_unf_cnt != {CNT_W{1'b1}})) begin
      r_rd_unf_cnt <= r_rd_unf_cnt + 1'b1;
    end
  end

  // Read pipeline. Data/tag registers only load when a result completes, so
  // they hold the last returned word between reads.
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             r_s1_vld;
      logic [WIDTH-1:0] r_s1_dat;
      logic [CW-1:0]    r_s1_ch;

      always_ff @(posedge i_rclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_s1_vld <= 1'b0;
          r_s1_dat <= '0;
          r_s1_ch  <= '0;
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
          r_rd_ch  <= '0;
        end else begin
          r_s1_vld <= w_rd_acc;
          if (w_rd_acc) begin
            r_s1_dat <= w_rd_word;
            r_s1_ch  <= w_rd_ch;
          end
          r_rvalid <= r_s1_vld;
          if (r_s1_vld) begin
            r_rdata <= r_s1_dat;
            r_rd_ch <= r_s1_ch;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge i_rclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
          r_rd_ch  <= '0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rdata <= w_rd_word;
            r_rd_ch <= w_rd_ch;
          end
        end
      end
    end
  endgenerate

  assign o_DATA       = r_rdata;
  assign o_rvalid     = r_rvalid;
  assign o_rd_ch      = r_rd_ch;
  assign o_wr_ovf_cnt = r_wr_ovf_cnt;
  assign o_rd_unf_cnt = r_rd_unf_cnt;

endmodule

// File: tb/tb_fifo_mem_mc.sv
// tb_fifo_mem_mc: bench for fifo_mem_mc, READ_LAT=1 and READ_LAT=2 instances driven in parallel.
// Latency: expected results come from a request history indexed by read-clock cycle.
// Backpressure: full/empty flags are driven directly to exercise blocked-access counting.
`timescale 1ns/100ps
module tb_fifo_mem_mc;

  logic        i_wclk = 1'b0;
  logic        i_rclk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_wr_en;
  logic [1:0]  i_wr_ch;
  logic [2:0]  i_wraddr;
  logic [3:0]  i_wbe;
  logic [31:0] i_DATA;
  logic [3:0]  i_full;
  logic        i_rd_en;
  logic [1:0]  i_rd_ch;
  logic [2:0]  i_rdaddr;
  logic [3:0]  i_empty;

  logic [31:0] d1, d2;
  logic        v1, v2;
  logic [1:0]  c1, c2;
  logic [7:0]  ovf1, ovf2, unf1, unf2;

  always #5    i_wclk = ~i_wclk;   // 100 MHz
  always #13.5 i_rclk = ~i_rclk;   // ~37 MHz

  fifo_mem_mc #(.READ_LAT(1)) u_l1 (
    .i_wclk(i_wclk), .i_rclk(i_rclk), .i_reset_n(i_reset_n),
    .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wraddr(i_wraddr), .i_wbe(i_wbe),
    .i_DATA(i_DATA), .i_full(i_full),
    .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .i_rdaddr(i_rdaddr), .i_empty(i_empty),
    .o_DATA(d1), .o_rvalid(v1), .o_rd_ch(c1),
    .o_wr_ovf_cnt(ovf1), .o_rd_unf_cnt(unf1)
  );

  fifo_mem_mc #(.READ_LAT(2)) u_l2 (
    .i_wclk(i_wclk), .i_rclk(i_rclk), .i_reset_n(i_reset_n),
    .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wraddr(i_wraddr), .i_wbe(i_wbe),
    .i_DATA(i_DATA), .i_full(i_full),
    .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .i_rdaddr(i_rdaddr), .i_empty(i_empty),
    .o_DATA(d2), .o_rvalid(v2), .o_rd_ch(c2),
    .o_wr_ovf_cnt(ovf2), .o_rd_unf_cnt(unf2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [4][8];
  int          wr_ovf = 0;
  int          rd_unf = 0;

  // Accepted-read history, one slot per read-clock edge since reset release.
  int          rcyc = 0;
  int          base = 1;
  logic        hacc [16];
  logic [31:0] hdat [16];
  logic [1:0]  hch  [16];

  initial forever begin
    @(posedge i_wclk or negedge i_reset_n);
    if (!i_reset_n) begin
      for (int c = 0; c < 4; c++)
        for (int a = 0; a < 8; a++) mmem[c][a] = 32'h0;
      wr_ovf = 0;
    end else if (i_wr_en) begin
      if (!i_full[i_wr_ch]) begin
        for (int k = 0; k < 4; k++)
          if (i_wbe[k]) mmem[i_wr_ch][i_wraddr][k*8 +: 8] = i_DATA[k*8 +: 8];
      end else begin
        wr_ovf = (wr_ovf >= 255) ? 255 : wr_ovf + 1;
      end
    end
  end

  initial forever begin
    @(posedge i_rclk or negedge i_reset_n);
    if (!i_reset_n) begin
      rd_unf = 0;
      base   = rcyc + 1;
    end else begin
      rcyc++;
      hacc[rcyc % 16] = 1'b0;
      if (i_rd_en) begin
        if (!i_empty[i_rd_ch]) begin
          hacc[rcyc % 16] = 1'b1;
          hdat[rcyc % 16] = mmem[i_rd_ch][i_rdaddr];
          hch[rcyc % 16]  = i_rd_ch;
        end else begin
          rd_unf = (rd_unf >= 255) ? 255 : rd_unf + 1;
        end
      end
    end
  end

  // Result for a READ_LAT=lat instance is the request accepted lat-1 edges ago;
  // with no such request the data/tag must hold their previous value.
  task automatic mon(input int lat, input logic v, input logic [31:0] d, input logic [1:0] c,
                     inout logic [31:0] ld, inout logic [1:0] lc);
    int   idx;
    logic ev;
    idx = rcyc - (lat - 1);
    ev  = 1'b0;
    if (idx >= base) ev = hacc[idx % 16];
    if (ev) begin
      ld = hdat[idx % 16];
      lc = hch[idx % 16];
    end
    chk($sformatf("rvalid_L%0d", lat), 32'(v), 32'(ev));
    chk($sformatf("rdata_L%0d", lat), d, ld);
    chk($sformatf("rd_ch_L%0d", lat), 32'(c), 32'(lc));
  endtask

  logic [31:0] last_d1 = 32'h0, last_d2 = 32'h0;
  logic [1:0]  last_c1 = 2'h0,  last_c2 = 2'h0;

  initial forever begin
    @(negedge i_rclk);
    if (!i_reset_n) begin
      last_d1 = 32'h0; last_d2 = 32'h0; last_c1 = 2'h0; last_c2 = 2'h0;
      chk("rst_rvalid_L1", 32'(v1), 32'h0);
      chk("rst_rvalid_L2", 32'(v2), 32'h0);
      chk("rst_rdata_L1", d1, 32'h0);
      chk("rst_rdata_L2", d2, 32'h0);
    end else begin
      mon(1, v1, d1, c1, last_d1, last_c1);
      mon(2, v2, d2, c2, last_d2, last_c2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int ch, input int a, input logic [31:0] d, input logic [3:0] be);
    i_wr_en  = 1'b1;
    i_wr_ch  = 2'(ch);
    i_wraddr = 3'(a);
    i_DATA   = d;
    i_wbe    = be;
    @(posedge i_wclk); #1;
    i_wr_en  = 1'b0;
  endtask

  task automatic rd(input int ch, input int a);
    i_rd_en  = 1'b1;
    i_rd_ch  = 2'(ch);
    i_rdaddr = 3'(a);
    @(posedge i_rclk); #1;
    i_rd_en  = 1'b0;
  endtask

  task automatic rwait(input int n);
    repeat (n) @(posedge i_rclk);
    #1;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_ovf_L1"}, 32'(ovf1), 32'(wr_ovf));
    chk({tag, "_ovf_L2"}, 32'(ovf2), 32'(wr_ovf));
    chk({tag, "_unf_L1"}, 32'(unf1), 32'(rd_unf));
    chk({tag, "_unf_L2"}, 32'(unf2), 32'(rd_unf));
  endtask

  initial begin
    i_wr_en = 1'b0; i_wr_ch = 2'd0; i_wraddr = 3'd0; i_wbe = 4'h0; i_DATA = 32'h0;
    i_full = 4'h0; i_rd_en = 1'b0; i_rd_ch = 2'd0; i_rdaddr = 3'd0; i_empty = 4'h0;

    // Reset state
    #40;
    chk("rst_ovf", 32'(ovf1), 32'h0);
    chk("rst_unf", 32'(unf2), 32'h0);
    @(negedge i_rclk); #0.3;
    i_reset_n = 1'b1;
    rwait(2);

    // Single write/read with full lane mask
    wr(2, 5, 32'hDEADBEEF, 4'hF);
    rd(2, 5);
    rwait(3);
    chk("dir_data_L1", d1, 32'hDEADBEEF);
    chk("dir_ch_L1", 32'(c1), 32'd2);
    chk("dir_data_L2", d2, 32'hDEADBEEF);

    // Lane-masked merge; zero mask writes nothing and is not counted
    wr(0, 0, 32'h11223344, 4'hF);
    wr(0, 0, 32'hAABBCCDD, 4'b0101);
    wr(0, 0, 32'hFFFFFFFF, 4'h0);
    rd(0, 0);
    rwait(3);
    chk("be_merge_L1", d1, 32'h11BB33DD);
    chk("be_merge_L2", d2, 32'h11BB33DD);
    chk("be0_ovf", 32'(ovf1), 32'h0);

    // Blocked writes saturate the overflow counter and leave ch1 untouched
    i_full = 4'b0010;
    for (int i = 0; i < 300; i++) wr(1, i % 8, $urandom, 4'hF);
    i_full = 4'h0;
    chk("ovf_sat_L1", 32'(ovf1), 32'd255);
    chk("ovf_sat_L2", 32'(ovf2), 32'd255);
    for (int a = 0; a < 8; a++) rd(1, a);
    rwait(3);
    chk("ch1_clean", d2, 32'h0);

    // Blocked reads on an empty channel
    i_empty = 4'b1000;
    for (int i = 0; i < 3; i++) rd(3, i);
    rwait(3);
    chk("unf3_L1", 32'(unf1), 32'd3);
    chk("unf3_L2", 32'(unf2), 32'd3);
    i_empty = 4'h0;

    // Back-to-back reads, ch3 preloaded with 0xA0..0xA3
    for (int a = 0; a < 4; a++) wr(3, a, 32'hA0 + 32'(a), 4'hF);
    i_rd_en = 1'b1; i_rd_ch = 2'd3;
    for (int a = 0; a < 4; a++) begin
      i_rdaddr = 3'(a);
      @(posedge i_rclk); #1;
    end
    i_rd_en = 1'b0;
    rwait(3);
    chk("b2b_last_L2", d2, 32'hA3);
    chk_cnts("b2b");

    // Random writes with random full flags and lane masks
    for (int i = 0; i < 150; i++) begin
      i_full = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      wr($urandom_range(0, 3), $urandom_range(0, 7), $urandom, 4'($urandom));
    end
    i_full = 4'h0;
    chk_cnts("rnd_wr");

    // Fill every channel with distinct patterns, then drain in order
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 8; a++)
        wr(c, a, (32'(c) << 28) | (32'(a) << 24) | ($urandom & 32'h00FF_FFFF), 4'hF);
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 8; a++) begin
        rd(c, a);
        if ($urandom_range(0, 3) == 0) rwait($urandom_range(1, 2));
      end
    rwait(3);

    // Random reads with random empty flags
    for (int i = 0; i < 120; i++) begin
      i_empty = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rd($urandom_range(0, 3), $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rwait(1);
    end
    i_empty = 4'h0;
    rwait(3);
    chk_cnts("rnd_rd");

    // Reset while a read is in flight
    rd(0, 0);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_rvalid_L1", 32'(v1), 32'h0);
    chk("midrst_rvalid_L2", 32'(v2), 32'h0);
    rwait(3);
    chk("midrst_data_L2", d2, 32'h0);
    chk("midrst_ovf", 32'(ovf1), 32'h0);
    chk("midrst_unf", 32'(unf2), 32'h0);
    @(negedge i_rclk); #0.3;
    i_reset_n = 1'b1;
    rwait(2);
    for (int i = 0; i < 12; i++) rd($urandom_range(0, 3), $urandom_range(0, 7));
    rwait(3);
    chk("post_rst_L1", d1, 32'h0);
    chk("post_rst_L2", d2, 32'h0);
    chk_cnts("end");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
